// File: rtl/pipeline_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_sequencer
// Description : Run-control and hazard sequencer for a 5-stage MIPS datapath.
//               Provides free-run and single-step execution, load-use stall
//               and branch flush control, HALT drain and an enabled-cycle
//               counter.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk               in   clock, all state on rising edge
//   rst               in   asynchronous reset, active low
//   i_start           in   pulse: begin / re-arm execution
//   i_step_mode       in   sampled with i_start: 1 = single-step, 0 = free run
//   i_step            in   step request level (acted on at rising edge)
//   i_halt_detected   in   HALT opcode currently in ID
//   i_branch_taken    in   branch/jump resolved taken in ID
//   i_id_ex_mem_read  in   EX instruction is a load
//   i_id_ex_rt        in   load destination in EX
//   i_if_id_rs        in   rs of ID instruction
//   i_if_id_rt        in   rt of ID instruction
//   o_enable          out  global pipeline / PC enable
//   o_pc_write        out  PC update allowed
//   o_if_id_write     out  IF/ID capture allowed
//   o_if_id_flush     out  zero IF/ID on next edge
//   o_id_ex_flush     out  bubble into ID/EX
//   o_halted          out  program finished, pipeline frozen
//   o_cycle_count     out  enabled cycles since last start (saturating)
// ============================================================================
module pipeline_sequencer #(
  parameter int REG_ADDR_BITS    = 5,
  parameter int DRAIN_CYCLES     = 4,
  parameter int CYCLE_COUNT_BITS = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic                        i_step_mode,
  input  logic                        i_step,
  input  logic                        i_halt_detected,
  input  logic                        i_branch_taken,
  input  logic                        i_id_ex_mem_read,
  input  logic [REG_ADDR_BITS-1:0]    i_id_ex_rt,
  input  logic [REG_ADDR_BITS-1:0]    i_if_id_rs,
  input  logic [REG_ADDR_BITS-1:0]    i_if_id_rt,
  output logic                        o_enable,
  output logic                        o_pc_write,
  output logic                        o_if_id_write,
  output logic                        o_if_id_flush,
  output logic                        o_id_ex_flush,
  output logic                        o_halted,
  output logic [CYCLE_COUNT_BITS-1:0] o_cycle_count
);

  // Guard against a zero-width counter when only one drain cycle is wanted.
  localparam int DRAIN_BITS = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_BITS-1:0] C_DRAIN_LOAD = DRAIN_BITS'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_STEP_WAIT = 3'd2,
    S_STEP      = 3'd3,
    S_DRAIN     = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t                      state_q,     state_d;
  logic [DRAIN_BITS-1:0]       drain_q,     drain_d;
  logic [CYCLE_COUNT_BITS-1:0] count_q,     count_d;
  logic                        step_prev_q, step_prev_d;

  logic w_load_use;
  logic w_enable;
  logic w_pc_write;
  logic w_if_id_write;
  logic w_if_id_flush;
  logic w_id_ex_flush;
  logic w_halted;

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  assign w_load_use = i_id_ex_mem_read && (i_id_ex_rt != '0) &&
                      ((i_id_ex_rt == i_if_id_rs) || (i_id_ex_rt == i_if_id_rt));

  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    count_d       = count_q;
    step_prev_d   = i_step;
    w_enable      = 1'b0;
    w_pc_write    = 1'b0;
    w_if_id_write = 1'b0;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;
    w_halted      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          count_d = '0;
          state_d = i_step_mode ? S_STEP_WAIT : S_RUN;
        end
      end

      S_RUN, S_STEP: begin
        w_enable = 1'b1;
        if (w_load_use) begin
          // Stall: the branch operand is stale, so the branch re-resolves
          // next cycle; a HALT seen now is not yet a valid ID instruction.
          w_id_ex_flush = 1'b1;
        end else begin
          w_pc_write    = 1'b1;
          w_if_id_write = 1'b1;
          w_if_id_flush = i_branch_taken;
        end

        if (i_halt_detected && !w_load_use) begin
          state_d = S_DRAIN;
          drain_d = C_DRAIN_LOAD;
        end else if (state_q == S_STEP) begin
          state_d = S_STEP_WAIT;
        end
      end

      S_STEP_WAIT: begin
        if (i_step && !step_prev_q) begin
          state_d = S_STEP;
        end
      end

      S_DRAIN: begin
        // Keep the back end running while nothing new enters past HALT.
        w_enable      = 1'b1;
        w_if_id_flush = 1'b1;
        if (drain_q == '0) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end

      S_DONE: begin
        w_halted = 1'b1;
        if (i_start) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (w_enable && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      drain_q     <= '0;
      count_q     <= '0;
      step_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      count_q     <= count_d;
      step_prev_q <= step_prev_d;
    end
  end

  assign o_enable      = w_enable;
  assign o_pc_write    = w_pc_write;
  assign o_if_id_write = w_if_id_write;
  assign o_if_id_flush = w_if_id_flush;
  assign o_id_ex_flush = w_id_ex_flush;
  assign o_halted      = w_halted;
  assign o_cycle_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_sequencer
// Description : Directed self-checking bench for pipeline_sequencer, with a
//               second 4-bit-counter instance for saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_start = 1'b0, i_step_mode = 1'b0, i_step = 1'b0;
  logic i_halt_detected = 1'b0, i_branch_taken = 1'b0, i_id_ex_mem_read = 1'b0;
  logic [4:0] i_id_ex_rt = '0, i_if_id_rs = '0, i_if_id_rt = '0;
  logic o_enable, o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_flush, o_halted;
  logic [31:0] o_cycle_count;

  logic i_start4 = 1'b0;
  logic o_enable4, o_pc_write4, o_if_id_write4, o_if_id_flush4, o_id_ex_flush4, o_halted4;
  logic [3:0] o_cycle_count4;

  int vectors = 0;
  int miscompares = 0;

  // ctl = {enable, pc_write, if_id_write, if_id_flush, id_ex_flush, halted}
  localparam logic [5:0] C_IDLE  = 6'b000000;
  localparam logic [5:0] C_RUN   = 6'b111000;
  localparam logic [5:0] C_RUNBR = 6'b111100;
  localparam logic [5:0] C_HAZ   = 6'b100010;
  localparam logic [5:0] C_DRAIN = 6'b100100;
  localparam logic [5:0] C_DONE  = 6'b000001;

  typedef struct {
    logic [5:0]  ctl;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t sb4[$];

  always #5 clk = ~clk;

  pipeline_sequencer #(.REG_ADDR_BITS(5), .DRAIN_CYCLES(4), .CYCLE_COUNT_BITS(32)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_step_mode(i_step_mode), .i_step(i_step),
    .i_halt_detected(i_halt_detected), .i_branch_taken(i_branch_taken),
    .i_id_ex_mem_read(i_id_ex_mem_read), .i_id_ex_rt(i_id_ex_rt),
    .i_if_id_rs(i_if_id_rs), .i_if_id_rt(i_if_id_rt),
    .o_enable(o_enable), .o_pc_write(o_pc_write), .o_if_id_write(o_if_id_write),
    .o_if_id_flush(o_if_id_flush), .o_id_ex_flush(o_id_ex_flush),
    .o_halted(o_halted), .o_cycle_count(o_cycle_count)
  );

  pipeline_sequencer #(.REG_ADDR_BITS(5), .DRAIN_CYCLES(4), .CYCLE_COUNT_BITS(4)) dut4 (
    .clk(clk), .rst(rst), .i_start(i_start4), .i_step_mode(1'b0), .i_step(1'b0),
    .i_halt_detected(1'b0), .i_branch_taken(1'b0),
    .i_id_ex_mem_read(1'b0), .i_id_ex_rt(5'd0),
    .i_if_id_rs(5'd0), .i_if_id_rt(5'd0),
    .o_enable(o_enable4), .o_pc_write(o_pc_write4), .o_if_id_write(o_if_id_write4),
    .o_if_id_flush(o_if_id_flush4), .o_id_ex_flush(o_id_ex_flush4),
    .o_halted(o_halted4), .o_cycle_count(o_cycle_count4)
  );

  task automatic push(input logic [5:0] ctl, input int cnt);
    exp_t e;
    e.ctl = ctl;
    e.cnt = 32'(cnt);
    sb.push_back(e);
  endtask

  task automatic compare_now(input string tag);
    exp_t e;
    logic [5:0] act;
    e   = sb.pop_front();
    act = {o_enable, o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_flush, o_halted};
    vectors++;
    assert (act === e.ctl) else begin
      miscompares++;
      $error("FAIL %s ctl observed=%b expected=%b", tag, act, e.ctl);
    end
    vectors++;
    assert (o_cycle_count === e.cnt) else begin
      miscompares++;
      $error("FAIL %s count observed=%0d expected=%0d", tag, o_cycle_count, e.cnt);
    end
  endtask

  // Inputs are already driven (posedge+1); check mid-cycle, then advance.
  task automatic cyc(input string tag, input logic [5:0] ctl, input int cnt);
    push(ctl, cnt);
    @(negedge clk);
    compare_now(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc4(input string tag, input logic en, input int cnt);
    exp_t e;
    exp_t g;
    e.ctl = {en, 5'b0};
    e.cnt = 32'(cnt);
    sb4.push_back(e);
    @(negedge clk);
    g = sb4.pop_front();
    vectors++;
    assert (o_enable4 === g.ctl[5]) else begin
      miscompares++;
      $error("FAIL %s enable observed=%b expected=%b", tag, o_enable4, g.ctl[5]);
    end
    vectors++;
    assert (o_cycle_count4 === g.cnt[3:0]) else begin
      miscompares++;
      $error("FAIL %s count observed=%0d expected=%0d", tag, o_cycle_count4, g.cnt[3:0]);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    push(C_IDLE, 0);
    compare_now("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    cyc("idle", C_IDLE, 0);

    // Free run, 10 cycles
    i_start = 1'b1; i_step_mode = 1'b0;
    cyc("start_run", C_IDLE, 0);
    i_start = 1'b0;
    for (int k = 0; k < 10; k++) cyc("run", C_RUN, k);

    // Load-use hazard overrides branch
    i_id_ex_mem_read = 1'b1; i_id_ex_rt = 5'd5; i_if_id_rs = 5'd5; i_branch_taken = 1'b1;
    cyc("hazard_rs", C_HAZ, 10);
    i_id_ex_rt = 5'd0;
    cyc("rt0_branch", C_RUNBR, 11);
    // rt match, HALT during hazard is ignored
    i_id_ex_rt = 5'd7; i_if_id_rt = 5'd7; i_if_id_rs = 5'd3; i_branch_taken = 1'b0;
    i_halt_detected = 1'b1;
    cyc("hazard_rt_halt", C_HAZ, 12);
    // HALT with branch: halt wins
    i_id_ex_mem_read = 1'b0; i_branch_taken = 1'b1;
    cyc("halt_branch", C_RUNBR, 13);
    i_halt_detected = 1'b0; i_branch_taken = 1'b0;

    // Drain for exactly 4 cycles; i_start ignored here
    i_start = 1'b1;
    cyc("drain0", C_DRAIN, 14);
    i_start = 1'b0;
    for (int k = 1; k < 4; k++) cyc("drain", C_DRAIN, 14 + k);
    cyc("done", C_DONE, 18);
    cyc("done_hold", C_DONE, 18);
    i_start = 1'b1;
    cyc("done_start", C_DONE, 18);
    i_start = 1'b0;
    cyc("idle_after_done", C_IDLE, 18);

    // Single-step mode
    i_start = 1'b1; i_step_mode = 1'b1;
    cyc("start_step", C_IDLE, 18);
    i_start = 1'b0;
    cyc("step_wait", C_IDLE, 0);
    i_step = 1'b1;
    cyc("step_edge", C_IDLE, 0);
    cyc("step_one", C_RUN, 0);
    for (int k = 0; k < 3; k++) cyc("step_held", C_IDLE, 1);
    i_step = 1'b0;
    cyc("step_low", C_IDLE, 1);
    i_step = 1'b1;
    cyc("step_edge2", C_IDLE, 1);
    cyc("step_two", C_RUN, 1);
    cyc("step_cnt", C_IDLE, 2);

    // Step into HALT, then reset mid-drain with the drain counter at 2
    i_step = 1'b0;
    cyc("step_low2", C_IDLE, 2);
    i_step = 1'b1;
    cyc("step_edge3", C_IDLE, 2);
    i_halt_detected = 1'b1;
    cyc("step_halt", C_RUN, 2);
    i_halt_detected = 1'b0;
    cyc("step_drain", C_DRAIN, 3);
    rst = 1'b0;
    #1;
    push(C_IDLE, 0);
    compare_now("async_rst");
    @(posedge clk); #1;
    rst = 1'b1;
    i_step = 1'b0;
    cyc("rst_idle", C_IDLE, 0);
    i_step = 1'b1;
    cyc("idle_ignore_step", C_IDLE, 0);
    cyc("idle_ignore_step2", C_IDLE, 0);
    i_step = 1'b0; i_step_mode = 1'b0;

    // Saturation on the 4-bit counter instance
    i_start4 = 1'b1;
    cyc4("sat_start", 1'b0, 0);
    i_start4 = 1'b0;
    for (int k = 0; k < 20; k++) cyc4("sat_run", 1'b1, (k < 15) ? k : 15);
    cyc4("sat_final", 1'b1, 15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
